// File: rtl/ifetch_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package ifetch_prefetch_buffer_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } pf_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/ifetch_prefetch_buffer_if.sv
// Memory fetch port and IF/ID output stream of the prefetch buffer.
interface ifetch_prefetch_buffer_if #(
    parameter int ADDR_W = 30
);
    import ifetch_prefetch_buffer_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;

    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [PC_W-1:0]     out_pc;
    logic [PC_W-1:0]     out_pcplus4;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output out_valid,
        output out_instr,
        output out_pc,
        output out_pcplus4,
        input  out_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_pcplus4,
        output out_ready
    );

endinterface

// File: rtl/ifetch_prefetch_buffer_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with flush and a flop-backed head.
module pf_sync_fifo
    import ifetch_prefetch_buffer_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head_data,
    output logic          head_valid,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    fetch_entry_t      mem_q [DEPTH];
    fetch_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Decoupled fetch front end: sequential word fetches into a FIFO, drained by IF/ID,
// with redirect flushing queued words and discarding a stale in-flight fetch.
module ifetch_prefetch_buffer
    import ifetch_prefetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 30,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [CNT_W-1:0]   count,
    ifetch_prefetch_buffer_if.master bus
);

    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_WIDE  = (CNT_W+1)'(DEPTH);

    pf_state_e         state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] stale_addr_q, stale_addr_d;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              push;
    logic              pop;
    logic              flush;
    logic [CNT_W-1:0]  fifo_count;
    logic              head_valid;
    logic [CNT_W:0]    level_after;
    logic              room_after_push;
    fetch_entry_t      push_data;
    fetch_entry_t      head_data;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            stale_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            stale_addr_q <= stale_addr_d;
        end
    end

    // The request only starts when a slot is free, so staying in FETCH after an ack
    // needs room for one more word once this cycle's push and pop have landed.
    always_comb begin
        level_after     = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
        room_after_push = (level_after < DEPTH_WIDE);
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        stale_addr_d = stale_addr_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        state_d = FETCH;
                    end else begin
                        // The outstanding request must complete on its original address.
                        state_d      = DROP;
                        stale_addr_d = fetch_pc_q[ADDR_W+1:2];
                    end
                end
                DROP: begin
                    state_d = bus.imem_ack ? FETCH : DROP;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_count < FULL_COUNT) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = room_after_push ? FETCH : IDLE;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        imem_req  = (state_q == FETCH) || (state_q == DROP);
        imem_addr = (state_q == DROP) ? stale_addr_q : fetch_pc_q[ADDR_W+1:2];
        push      = (state_q == FETCH) && bus.imem_ack && !redirect_valid;
        flush     = redirect_valid;
        pop       = head_valid && bus.out_ready;
        push_data = '{pc: fetch_pc_q, instr: bus.imem_rdata};
    end

    pf_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = imem_addr;
    assign bus.out_valid   = head_valid;
    assign bus.out_instr   = head_data.instr;
    assign bus.out_pc      = head_data.pc;
    assign bus.out_pcplus4 = head_data.pc + 32'd4;
    assign count           = fifo_count;

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Directed bench for ifetch_prefetch_buffer against a memory with a programmable ack delay.
module tb_ifetch_prefetch_buffer;
    import ifetch_prefetch_buffer_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 30;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int errors    = 0;
    int checks    = 0;
    int ack_wait  = 0;
    int wait_cnt  = 0;
    int ack_total = 0;

    ifetch_prefetch_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    ifetch_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .count          (count),
        .bus            (bus)
    );

    always #5 clock = ~clock;

    // Memory acks once a request has waited ack_wait cycles; data is derived from the address.
    assign bus.imem_ack   = bus.imem_req && (wait_cnt >= ack_wait);
    assign bus.imem_rdata = 32'hA500_0000 ^ {2'b00, bus.imem_addr};

    always @(posedge clock) begin
        if (!reset || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (bus.imem_req && bus.imem_ack) ack_total <= ack_total + 1;
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return 32'hA500_0000 ^ {2'b00, pc[31:2]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        ack_wait       = 0;
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        bus.out_ready  = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b expected 0", bus.imem_req); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.out_valid); end
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if (bus.out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00000000", bus.out_pc); end
        checks++;
        if (bus.out_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 00000000", bus.out_instr); end
        checks++;
        if (bus.out_pcplus4 !== 32'h4) begin errors++; $display("[TB] FAIL reset_pcplus4: got %h expected 00000004", bus.out_pcplus4); end
        redirect_valid = 1'b0;
        reset          = 1'b1;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0) begin
            errors++;
            $display("[TB] FAIL reset_first_req: got req=%0b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        ack_wait = 0;
        reset_dut();
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'(k - 1)) begin
                errors++;
                $display("[TB] FAIL stream_addr: got req=%0b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, 30'(k - 1));
            end
            if (k >= 2) begin
                exp_pc = 32'((k - 2) * 4);
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_pcplus4 !== exp_pc + 32'd4
                    || bus.out_instr !== exp_instr(exp_pc)) begin
                    errors++;
                    $display("[TB] FAIL stream_out: got v=%0b pc=%h pc4=%h instr=%h expected v=1 pc=%h pc4=%h instr=%h",
                             bus.out_valid, bus.out_pc, bus.out_pcplus4, bus.out_instr, exp_pc, exp_pc + 32'd4, exp_instr(exp_pc));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          start_acks;
        logic [31:0] exp_pc;
        bit          seen_req;
        ack_wait = 0;
        reset_dut();
        start_acks = ack_total;
        repeat (10) tick();
        checks++;
        if (ack_total - start_acks != 4) begin errors++; $display("[TB] FAIL full_acks: got %0d expected 4", ack_total - start_acks); end
        checks++;
        if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL full_req: got %0b expected 0", bus.imem_req); end
        checks++;
        if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", count); end
        bus.out_ready = 1'b1;
        exp_pc   = 32'h0;
        seen_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== exp_instr(exp_pc)) begin
                errors++;
                $display("[TB] FAIL drain_seq: got v=%0b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         bus.out_valid, bus.out_pc, bus.out_instr, exp_pc, exp_instr(exp_pc));
            end
            if (bus.imem_req === 1'b1 && !seen_req) begin
                seen_req = 1'b1;
                checks++;
                if (bus.imem_addr !== 30'h4) begin errors++; $display("[TB] FAIL resume_addr: got %h expected 00000004", bus.imem_addr); end
            end
            exp_pc = exp_pc + 32'd4;
            tick();
        end
        checks++;
        if (!seen_req) begin errors++; $display("[TB] FAIL resume_req: got no request expected one within 10 cycles"); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_slow_redirect();
        ack_wait = 2;
        reset_dut();
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0 || bus.imem_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL slow_wait0: got req=%0b addr=%h ack=%0b expected 1 0 0", bus.imem_req, bus.imem_addr, bus.imem_ack);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0) begin
            errors++;
            $display("[TB] FAIL slow_wait1: got req=%0b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0) begin
            errors++;
            $display("[TB] FAIL drop_hold: got req=%0b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
        end
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_flush: got count=%0d v=%0b expected 0 0", count, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h40) begin
            errors++;
            $display("[TB] FAIL redirect_addr: got req=%0b addr=%h expected req=1 addr=40", bus.imem_req, bus.imem_addr);
        end
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_pushed: got v=%0b expected 0", bus.out_valid); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_instr !== exp_instr(32'h100)) begin
            errors++;
            $display("[TB] FAIL redirect_out: got v=%0b pc=%h instr=%h expected v=1 pc=00000100 instr=%h",
                     bus.out_valid, bus.out_pc, bus.out_instr, exp_instr(32'h100));
        end
        ack_wait = 0;
    endtask

    task automatic test_redirect_ack_pop();
        ack_wait = 0;
        reset_dut();
        tick();
        tick();
        tick();
        checks++;
        if (count !== 3'd2 || bus.imem_ack !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rap_setup: got count=%0d ack=%0b v=%0b expected 2 1 1", count, bus.imem_ack, bus.out_valid);
        end
        bus.out_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        bus.out_ready  = 1'b0;
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rap_flush: got count=%0d v=%0b expected 0 0", count, bus.out_valid);
        end
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h80) begin
            errors++;
            $display("[TB] FAIL rap_addr: got req=%0b addr=%h expected req=1 addr=80", bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL rap_out: got v=%0b pc=%h count=%0d expected v=1 pc=00000200 count=1", bus.out_valid, bus.out_pc, count);
        end
    endtask

    task automatic test_wrap();
        ack_wait = 0;
        reset_dut();
        bus.out_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h3FFF_FFFE) begin
            errors++;
            $display("[TB] FAIL wrap_addr0: got req=%0b addr=%h expected req=1 addr=3ffffffe", bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFFFF_FFF8 || bus.out_pcplus4 !== 32'hFFFF_FFFC
            || bus.out_instr !== exp_instr(32'hFFFF_FFF8)) begin
            errors++;
            $display("[TB] FAIL wrap_out0: got v=%0b pc=%h pc4=%h instr=%h expected v=1 pc=fffffff8 pc4=fffffffc instr=%h",
                     bus.out_valid, bus.out_pc, bus.out_pcplus4, bus.out_instr, exp_instr(32'hFFFF_FFF8));
        end
        checks++;
        if (bus.imem_addr !== 30'h3FFF_FFFF) begin errors++; $display("[TB] FAIL wrap_addr1: got %h expected 3fffffff", bus.imem_addr); end
        tick();
        checks++;
        if (bus.out_pc !== 32'hFFFF_FFFC || bus.out_pcplus4 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_out1: got pc=%h pc4=%h expected pc=fffffffc pc4=00000000", bus.out_pc, bus.out_pcplus4);
        end
        checks++;
        if (bus.imem_addr !== 30'h0) begin errors++; $display("[TB] FAIL wrap_addr2: got %h expected 00000000", bus.imem_addr); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_pcplus4 !== 32'h4 || bus.out_instr !== exp_instr(32'h0)) begin
            errors++;
            $display("[TB] FAIL wrap_out2: got v=%0b pc=%h pc4=%h instr=%h expected v=1 pc=00000000 pc4=00000004 instr=%h",
                     bus.out_valid, bus.out_pc, bus.out_pcplus4, bus.out_instr, exp_instr(32'h0));
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_request();
        ack_wait = 0;
        reset_dut();
        repeat (4) tick();
        checks++;
        if (count !== 3'd3 || bus.imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_setup: got count=%0d req=%0b expected 3 1", count, bus.imem_req);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (bus.imem_req !== 1'b0 || count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got req=%0b count=%0d v=%0b pc=%h expected 0 0 0 00000000",
                     bus.imem_req, count, bus.out_valid, bus.out_pc);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0) begin
            errors++;
            $display("[TB] FAIL midreset_restart: got req=%0b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL midreset_out: got v=%0b pc=%h count=%0d expected v=1 pc=00000000 count=1", bus.out_valid, bus.out_pc, count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_slow_redirect();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch_buffer.md
Name: ifetch_prefetch_buffer

Overview:
- Decoupled instruction-fetch front end between the instruction memory and the pipeline's IF/ID register.
- Issues sequential word fetches over a req/ack memory port that may take several cycles, and queues {pc, instr} pairs in a small FIFO.
- Presents the pairs to IF/ID through a valid/ready handshake.
- A redirect (branch/jump target) flushes queued words and discards any stale in-flight fetch.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
ADDR_W, 30, instruction-memory word-address width
RESET_PC, 32'h0000_0000, first fetch byte address after reset

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-low; sampled on the rising edge of clock
redirect_valid  in  1  one-cycle pulse; load new fetch PC and flush
redirect_pc  in  32  redirect byte address; bits [1:0] ignored
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  ADDR_W  word address (fetch_pc >> 2); stable while imem_req is high
imem_ack  in  1  completes the request; only meaningful while imem_req is high
imem_rdata  in  32  instruction word; valid in the imem_ack cycle
out_valid  out  1  FIFO head valid
out_ready  in  1  IF/ID accepts the head (IF/ID write enable)
out_instr  out  32  head instruction
out_pc  out  32  head byte address
out_pcplus4  out  32  out_pc + 4
count  out  $clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty.
  - imem_req=0, out_valid=0, count=0; out_instr/out_pc=0, out_pcplus4=4.
  - Reset overrides every other input, including mid-request. The memory must tolerate a dropped request.
- imem_req = (state==FETCH || state==DROP). imem_addr = fetch_pc[ADDR_W+1:2]. At most one request is outstanding.
- Pop = out_valid && out_ready. The head advances on the next edge.
- Push happens on imem_ack in FETCH: {fetch_pc, imem_rdata} is written. The data appears on out_* at the earliest one cycle after the ack; there is no combinational bypass.
- States and transitions (redirect has top priority):
  - IDLE: if count<DEPTH, go to FETCH; else stay.
  - FETCH, ack with no redirect: push; fetch_pc += 4. Stay in FETCH if (count+1-pop)<DEPTH, else go to IDLE.
  - FETCH, no ack: hold. fetch_pc and imem_addr must not change.
  - DROP: the request for the stale address stays asserted. On ack, discard imem_rdata and go to FETCH, where the address is already the redirect target.
- Redirect in any state:
  - Flush FIFO: count=0 and out_valid=0 on the next cycle. A pop in the same cycle is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - IDLE -> FETCH.
  - FETCH with no ack -> DROP.
  - FETCH with ack the same cycle: discard the data, go to FETCH.
  - DROP with no ack: stay in DROP. DROP with ack: go to FETCH.
- Full FIFO: no new request is issued. A request already in FETCH only exists if a slot was reserved, so a push never overflows.
- Simultaneous push and pop with count==DEPTH-1 or count==DEPTH: count changes by push-pop. Wrap-around of the read/write pointers is modulo DEPTH.
- fetch_pc arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Latency:
  - From reset release, the first imem_req is seen in the cycle after the first edge with reset==1.
  - From a redirect in cycle N with a single-cycle ack, imem_req carries the target in cycle N+1 and out_valid rises in cycle N+2.
- Assertions for the verification engineer:
  - imem_addr stable while imem_req && !imem_ack.
  - count <= DEPTH.
  - No push when count==DEPTH && !pop.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, DROP), RESET_PC default, and the instruction-word width.
- One natural sub-module, pf_sync_fifo: parameterised DEPTH×64 storage, synchronous active-low reset, flush input, push/pop, count output, registered head.

Test Plan:
1. Reset release, zero-wait memory, out_ready=1 -> imem_addr 0,1,2,3; out_pc 0,4,8,C on consecutive cycles; out_pcplus4 = out_pc+4.
2. out_ready=0 with DEPTH=4 -> exactly 4 acks, then imem_req=0 and count=4. Raise out_ready -> fetch resumes at pc 0x10 with no lost or duplicated word.
3. Memory with a 3-cycle ack, redirect to 0x0000_0103 in the second wait cycle -> imem_addr held until the ack, stale data dropped, next request at word 0x40, out_pc=0x100.
4. Redirect on the same cycle as an ack and a pop with count=2 -> next cycle count=0, out_valid=0; next request targets the redirect address.
5. redirect_pc=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
6. Reset asserted while imem_req=1 and count=3 -> next cycle imem_req=0, count=0, state IDLE; restart fetches from RESET_PC.
